pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline backbone that generalises the fixed five-stage valid/allowin chain of the CPU top into an NSTAGE-deep chain.
- Holds each stage's valid bit and payload bus. Drives allowin backward and valid forward.
- Supports per-stage ready_go stalls, in-flight payload update, and a flush of the younger stages.
- Keeps retire/stall/flush performance counters. It is the common skeleton for the next core revision.

Parameters:
- NSTAGE, 5, number of pipeline stages; stage 0 is the youngest (IF side), stage NSTAGE-1 the oldest (WB side); minimum 2
- DW, 64, payload bus width per stage
- CW, 32, performance counter width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers a payload to stage 0
- in_allowin  output  1  stage 0 can accept this cycle
- in_bus  input  DW  payload offered to stage 0
- ready_go  input  NSTAGE  bit i: stage i has finished its work and may advance
- upd_en  input  NSTAGE  bit i: the payload forwarded out of stage i is replaced by upd_data slice i
- upd_data  input  NSTAGE*DW  replacement payloads; slice i = bits [i*DW +: DW]
- flush_req  input  1  kill stages 0..flush_stage
- flush_stage  input  $clog2(NSTAGE)  oldest stage to kill; values >= NSTAGE clamp to NSTAGE-1
- out_valid  output  1  oldest stage presents a finished payload
- out_ready  input  1  consumer accepts
- out_bus  output  DW  outgoing payload
- stage_valid  output  NSTAGE  valid bits per stage, exported for hazard and forwarding logic
- stage_bus  output  NSTAGE*DW  registered payload per stage
- cnt_retire  output  CW  number of out_valid&out_ready handshakes
- cnt_stall  output  CW  cycles with in_valid & ~in_allowin
- cnt_flush  output  CW  cycles with flush_req high

Behaviour:
- State: v[i], b[i] for i = 0..NSTAGE-1.
- kill[i] = flush_req & (i <= clamped flush_stage).
- go[i] = v[i] & ready_go[i] & ~kill[i].
- fwd[i] = upd_en[i] ? upd_data[i] : b[i]. When i = NSTAGE-1, out_bus = fwd[NSTAGE-1].
- allowin[NSTAGE-1] = ~v[NSTAGE-1] | (ready_go[NSTAGE-1] & out_ready).
- allowin[i] = ~v[i] | (ready_go[i] & allowin[i+1]). Computed combinationally; kill does not feed allowin, so there are no loops.
- in_allowin = allowin[0].
- out_valid = go[NSTAGE-1].
- Stage update each clock, in priority order:
  1. reset: all v, b and counters go to 0.
  2. kill[i]: v[i] <= 0, and b[i] holds.
  3. allowin[i]: v[i] <= (i == 0 ? in_valid : go[i-1]). When the incoming valid is 1, b[i] <= (i == 0 ? in_bus : fwd[i-1]).
  4. Otherwise v[i] and b[i] hold.
- Flush at stage k discards stages 0..k in the same cycle. A payload offered on in_bus that cycle is consumed (in_allowin reported normally) and dropped. Stage k+1 receives a bubble. Stages above k advance normally.
- Stage bus registers load only on a valid transfer, which keeps toggling down on bubbles.
- Latency: a payload accepted at edge t appears on out_valid after edge t+NSTAGE-1 when there are no stalls. Throughput is one payload per cycle.
- Full condition: all v set and out_ready = 0 drives in_allowin to 0 in the same cycle.
- Simultaneous out handshake and input at full: accepted, because allowin ripples through.
- Counters: increment by 1 per qualifying cycle and wrap modulo 2^CW. cnt_retire and cnt_flush increment even when both events occur in the same cycle.
- Reset mid-operation: all in-flight payloads are lost. Outputs go to 0 on the next edge: out_valid = 0, in_allowin = 1 afterwards.

Decomposition:
- Shared package pipe_pkg holds:
  - default NSTAGE, DW and CW constants
  - the index-width function for flush_stage
  - the slice helper for the packed NSTAGE*DW buses
- Sub-module pipe_stage_reg holds one stage's valid and payload register, with inputs kill, allowin, in_valid and in_bus.
- pipe_ctrl generates NSTAGE instances of pipe_stage_reg and adds the allowin chain and the counters.

Test Plan:
- Fill: NSTAGE=5, ready_go=all 1, out_ready=1, feed 0x1..0x8 back-to-back. Required: first out_valid 4 cycles after the first accept, outputs 0x1..0x8 in order with no gaps, cnt_retire=8, cnt_stall=0.
- Backpressure: out_ready=0, in_valid held with 0x10..0x16. Required: exactly 5 accepted, then in_allowin=0. cnt_stall counts every held cycle (3 after 8 cycles). Raising out_ready drains 0x10..0x14 in order, then 0x15, 0x16.
- Mid stall: ready_go[2]=0 for 3 cycles with a full pipe. Required: stages 0..2 hold their payloads, stages 3..4 drain, one bubble appears at stage 3 per stalled cycle, and there is no duplication or loss.
- Flush: pipe full with 0xA0..0xA4 (0xA4 oldest), flush_req=1, flush_stage=2, for one cycle. Required: stage_valid=5'b11000 → next cycle, only 0xA4 and 0xA3 retire, the offered in_bus is dropped, cnt_flush=1.
- Update: upd_en[3]=1 with upd_data slice 3 = 0xDEAD while 0xB0 is in stage 3 advancing. Required: out_bus=0xDEAD for that item, and neighbouring items are unchanged.
- Reset mid-run: assert reset for 1 cycle with a full pipe. Required: stage_valid=0, out_valid=0, all counters 0, in_allowin=1. The next accepted 0xC0 emerges after the nominal latency.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared defaults and index/slice helpers for the pipeline backbone.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int C_NSTAGE_DEF = 5;
    localparam int C_DW_DEF     = 64;
    localparam int C_CW_DEF     = 32;

    // Width of a stage index; never below one bit so the port always exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of slice idx in a packed bus of dw-wide slices.
    function automatic int slice_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : One pipeline stage: valid bit plus payload register.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DW = C_DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_kill,
    input  logic          i_allowin,
    input  logic          i_valid,
    input  logic [DW-1:0] i_bus,
    output logic          o_valid,
    output logic [DW-1:0] o_bus
);

    logic          r_valid;
    logic [DW-1:0] r_bus;

    // Kill wins over a transfer; the payload only loads on a real item.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else if (i_kill) begin
            r_valid <= 1'b0;
        end else if (i_allowin) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_bus <= i_bus;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_bus   = r_bus;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : NSTAGE-deep valid/allowin pipeline chain with flush, in-flight
//            payload update and retire/stall/flush counters.
// Revision : 1.0
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NSTAGE = C_NSTAGE_DEF,
    parameter int DW     = C_DW_DEF,
    parameter int CW     = C_CW_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_allowin,
    input  logic [DW-1:0]              in_bus,
    input  logic [NSTAGE-1:0]          ready_go,
    input  logic [NSTAGE-1:0]          upd_en,
    input  logic [NSTAGE*DW-1:0]       upd_data,
    input  logic                       flush_req,
    input  logic [idx_w(NSTAGE)-1:0]   flush_stage,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_bus,
    output logic [NSTAGE-1:0]          stage_valid,
    output logic [NSTAGE*DW-1:0]       stage_bus,
    output logic [CW-1:0]              cnt_retire,
    output logic [CW-1:0]              cnt_stall,
    output logic [CW-1:0]              cnt_flush
);

    localparam int C_FSW = idx_w(NSTAGE);

    logic [NSTAGE-1:0]    w_v;
    logic [NSTAGE-1:0]    w_kill;
    logic [NSTAGE-1:0]    w_go;
    logic [NSTAGE-1:0]    w_allowin;
    logic [NSTAGE-1:0]    w_in_valid;
    logic [NSTAGE*DW-1:0] w_fwd;
    logic [NSTAGE*DW-1:0] w_in_bus;
    logic [NSTAGE*DW-1:0] w_bus;
    logic [C_FSW-1:0]     w_fs;

    logic [CW-1:0] r_cnt_retire;
    logic [CW-1:0] r_cnt_stall;
    logic [CW-1:0] r_cnt_flush;

    assign w_fs = (int'(flush_stage) >= NSTAGE) ? C_FSW'(NSTAGE - 1) : flush_stage;

    // Allowin ripples from the oldest stage back to stage 0; kill is left out.
    always_comb begin
        logic w_acc;
        w_allowin = '0;
        w_acc     = ~w_v[NSTAGE-1] | (ready_go[NSTAGE-1] & out_ready);
        w_allowin[NSTAGE-1] = w_acc;
        for (int i = NSTAGE - 2; i >= 0; i--) begin
            w_acc        = ~w_v[i] | (ready_go[i] & w_acc);
            w_allowin[i] = w_acc;
        end
    end

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        localparam int LO = slice_lo(i, DW);

        assign w_kill[i]        = flush_req & (int'(w_fs) >= i);
        assign w_go[i]          = w_v[i] & ready_go[i] & ~w_kill[i];
        assign w_fwd[LO +: DW]  = upd_en[i] ? upd_data[LO +: DW] : w_bus[LO +: DW];

        if (i == 0) begin : g_head
            assign w_in_valid[i]      = in_valid;
            assign w_in_bus[LO +: DW] = in_bus;
        end else begin : g_body
            assign w_in_valid[i]      = w_go[i-1];
            assign w_in_bus[LO +: DW] = w_fwd[LO-DW +: DW];
        end

        pipe_stage_reg #(
            .DW(DW)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .i_kill   (w_kill[i]),
            .i_allowin(w_allowin[i]),
            .i_valid  (w_in_valid[i]),
            .i_bus    (w_in_bus[LO +: DW]),
            .o_valid  (w_v[i]),
            .o_bus    (w_bus[LO +: DW])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_retire <= '0;
            r_cnt_stall  <= '0;
            r_cnt_flush  <= '0;
        end else begin
            if (out_valid & out_ready) begin
                r_cnt_retire <= r_cnt_retire + CW'(1);
            end
            if (in_valid & ~in_allowin) begin
                r_cnt_stall <= r_cnt_stall + CW'(1);
            end
            if (flush_req) begin
                r_cnt_flush <= r_cnt_flush + CW'(1);
            end
        end
    end

    assign in_allowin  = w_allowin[0];
    assign out_valid   = w_go[NSTAGE-1];
    assign out_bus     = w_fwd[slice_lo(NSTAGE-1, DW) +: DW];
    assign stage_valid = w_v;
    assign stage_bus   = w_bus;
    assign cnt_retire  = r_cnt_retire;
    assign cnt_stall   = r_cnt_stall;
    assign cnt_flush   = r_cnt_flush;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed and randomized checks of pipe_ctrl against a slot model.
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int DW = 64;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_allowin;
    logic [DW-1:0]    in_bus;
    logic [NS-1:0]    ready_go;
    logic [NS-1:0]    upd_en;
    logic [NS*DW-1:0] upd_data;
    logic             flush_req;
    logic [2:0]       flush_stage;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_bus;
    logic [NS-1:0]    stage_valid;
    logic [NS*DW-1:0] stage_bus;
    logic [CW-1:0]    cnt_retire;
    logic [CW-1:0]    cnt_stall;
    logic [CW-1:0]    cnt_flush;

    pipe_ctrl #(.NSTAGE(NS), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_allowin (in_allowin),
        .in_bus     (in_bus),
        .ready_go   (ready_go),
        .upd_en     (upd_en),
        .upd_data   (upd_data),
        .flush_req  (flush_req),
        .flush_stage(flush_stage),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bus    (out_bus),
        .stage_valid(stage_valid),
        .stage_bus  (stage_bus),
        .cnt_retire (cnt_retire),
        .cnt_stall  (cnt_stall),
        .cnt_flush  (cnt_flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [NS*DW-1:0] act, input logic [NS*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: one slot per stage holding an occupied flag and a payload.
    logic          mv[NS];
    logic [DW-1:0] mb[NS];
    logic [CW-1:0] m_ret, m_stall, m_flush;
    logic          e_al[NS], e_go[NS], e_kl[NS];
    logic [DW-1:0] e_fw[NS];

    logic [DW-1:0] ret_q[$];
    int            rc_q[$];
    int            ncyc = 0;
    int            first_acc = -1;
    int            first_out = -1;

    always @(negedge clk) begin
        int fsc;
        logic [NS-1:0]    sv;
        logic [NS*DW-1:0] sb;
        ncyc++;
        fsc = (int'(flush_stage) > NS - 1) ? NS - 1 : int'(flush_stage);
        for (int i = 0; i < NS; i++) begin
            e_kl[i] = flush_req && (i <= fsc);
            e_go[i] = mv[i] && ready_go[i] && !e_kl[i];
            e_fw[i] = upd_en[i] ? upd_data[i*DW +: DW] : mb[i];
        end
        // A slot can take a new item if it is empty or its occupant leaves now.
        e_al[NS-1] = !mv[NS-1] || (ready_go[NS-1] && out_ready);
        for (int i = NS - 2; i >= 0; i--) begin
            e_al[i] = !mv[i] || (ready_go[i] && e_al[i+1]);
        end
        for (int i = 0; i < NS; i++) begin
            sv[i]         = mv[i];
            sb[i*DW +: DW] = mb[i];
        end
        chk("in_allowin", in_allowin, e_al[0]);
        chk("out_valid", out_valid, e_go[NS-1]);
        if (e_go[NS-1]) chk("out_bus", out_bus, e_fw[NS-1]);
        chk("stage_valid", stage_valid, sv);
        chk("stage_bus", stage_bus, sb);
        chk("cnt_retire", cnt_retire, m_ret);
        chk("cnt_stall", cnt_stall, m_stall);
        chk("cnt_flush", cnt_flush, m_flush);
        if (out_valid && out_ready) begin
            ret_q.push_back(out_bus);
            rc_q.push_back(ncyc);
        end
        if (first_out < 0 && out_valid) first_out = ncyc;
        if (first_acc < 0 && in_valid && in_allowin) first_acc = ncyc;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                mv[i] <= 1'b0;
                mb[i] <= '0;
            end
            m_ret   <= '0;
            m_stall <= '0;
            m_flush <= '0;
        end else begin
            if (e_go[NS-1] && out_ready) m_ret <= m_ret + 1;
            if (in_valid && !e_al[0])    m_stall <= m_stall + 1;
            if (flush_req)               m_flush <= m_flush + 1;
            for (int i = 0; i < NS; i++) begin
                if (e_kl[i]) begin
                    mv[i] <= 1'b0;
                end else if (e_al[i]) begin
                    if (i == 0) begin
                        mv[i] <= in_valid;
                        if (in_valid) mb[i] <= in_bus;
                    end else begin
                        mv[i] <= e_go[i-1];
                        if (e_go[i-1]) mb[i] <= e_fw[i-1];
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ret_q.delete();
        rc_q.delete();
        first_acc = -1;
        first_out = -1;
    endtask

    task automatic chk_ret(input string nm, input int n, input logic [DW-1:0] base, input int step);
        chk({nm, "_count"}, ret_q.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] e;
            e = base + DW'(i * step);
            chk({nm, "_data"}, ret_q[i], e);
        end
    endtask

    initial begin
        int nacc;
        reset = 1'b1; in_valid = 1'b0; in_bus = '0; ready_go = '1; upd_en = '0;
        upd_data = '0; flush_req = 1'b0; flush_stage = '0; out_ready = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_allowin", in_allowin, 1);
        chk("rst_cnt_retire", cnt_retire, 0);
        cyc();

        // Fill: 1..8 back to back
        clr();
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_bus = DW'(k);
            cyc();
        end
        in_valid = 1'b0;
        repeat (10) cyc();
        chk_ret("fill", 8, 64'h1, 1);
        chk("fill_gapless", rc_q.size() == 8 ? rc_q[7] - rc_q[0] : -1, 7);
        // accept sample to first output sample spans NS edges
        chk("fill_latency", first_out - first_acc, NS);
        chk("fill_cnt_retire", cnt_retire, 8);
        chk("fill_cnt_stall", cnt_stall, 0);

        // Backpressure
        clr();
        out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
        for (int c = 0; c < 8; c++) begin
            in_bus = 64'h10 + DW'(nacc);
            @(negedge clk);
            if (in_allowin) nacc++;
            cyc();
        end
        @(negedge clk);
        chk("bp_accepted", nacc, 5);
        chk("bp_allowin", in_allowin, 0);
        chk("bp_cnt_stall", cnt_stall, 3);
        cyc();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && nacc < 7; c++) begin
            in_bus = 64'h10 + DW'(nacc);
            @(negedge clk);
            if (in_allowin) nacc++;
            cyc();
        end
        in_valid = 1'b0;
        repeat (10) cyc();
        chk_ret("bp", 7, 64'h10, 1);

        // Mid stall at stage 2
        clr();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_bus = 64'h20 + DW'(k);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; ready_go = 5'b11011;
        repeat (3) cyc();
        @(negedge clk);
        chk("stall_valid", stage_valid, 5'b00111);
        chk("stall_s0", stage_bus[0 +: DW], 64'h24);
        chk("stall_s1", stage_bus[DW +: DW], 64'h23);
        chk("stall_s2", stage_bus[2*DW +: DW], 64'h22);
        cyc();
        ready_go = '1;
        repeat (8) cyc();
        chk_ret("stall", 5, 64'h20, 1);

        // Flush stages 0..2 with a full pipe
        clr();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_bus = 64'hA4 - DW'(k);
            cyc();
        end
        flush_req = 1'b1; flush_stage = 3'd2; in_bus = 64'hEE;
        cyc();
        flush_req = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", stage_valid, 5'b11000);
        chk("flush_cnt", cnt_flush, 1);
        cyc();
        out_ready = 1'b1;
        repeat (8) cyc();
        chk_ret("flush", 2, 64'hA4, -1);

        // In-flight update at stage 3
        clr();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_bus = 64'hB0 + DW'(k);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        upd_en = 5'b01000; upd_data[3*DW +: DW] = 64'hDEAD;
        @(negedge clk);
        chk("upd_s3_reg", stage_bus[3*DW +: DW], 64'hB0);
        cyc();
        upd_en = '0; upd_data = '0;
        repeat (8) cyc();
        chk("upd_count", ret_q.size(), 3);
        chk("upd_item0", ret_q[0], 64'hDEAD);
        chk("upd_item1", ret_q[1], 64'hB1);
        chk("upd_item2", ret_q[2], 64'hB2);

        // Reset mid-run with a full pipe
        clr();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_bus = 64'hD0 + DW'(k);
            cyc();
        end
        in_valid = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_valid", stage_valid, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_allowin", in_allowin, 1);
        chk("mrst_counters", {cnt_retire, cnt_stall, cnt_flush}, 0);
        cyc();
        clr();
        out_ready = 1'b1; in_valid = 1'b1; in_bus = 64'hC0;
        cyc();
        in_valid = 1'b0;
        repeat (8) cyc();
        chk("mrst_latency", first_out - first_acc, NS);
        chk("mrst_count", ret_q.size(), 1);
        chk("mrst_item", ret_q[0], 64'hC0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_bus    = {$urandom, $urandom};
            for (int i = 0; i < NS; i++) begin
                ready_go[i] = ($urandom_range(0, 4) != 0);
                upd_en[i]   = ($urandom_range(0, 7) == 0);
                upd_data[i*DW +: DW] = {$urandom, $urandom};
            end
            flush_req   = ($urandom_range(0, 15) == 0);
            flush_stage = 3'($urandom_range(0, 7));
            out_ready   = ($urandom_range(0, 9) < 7);
            cyc();
        end
        reset = 1'b0; in_valid = 1'b0; ready_go = '1; upd_en = '0;
        flush_req = 1'b0; out_ready = 1'b1;
        repeat (10) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
